// File: rtl/vexec_seq.sv
// vexec_seq: vector execute sequencer, walks an LMUL register group through RD/EX/WB with tail-masked writes.
// Optional VEXEC_VX_EN adds a scalar operand (i_vx/i_scalar) replicated across operand B.
module vexec_seq #(
    parameter int VLEN = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [5:0]        i_ctrl,
    input  logic [10:0]       i_sew,
    input  logic [1:0]        i_lmul,
    input  logic [7:0]        i_vl,
    input  logic [4:0]        i_vd,
    input  logic [4:0]        i_vs1,
    input  logic [4:0]        i_vs2,
    output logic [4:0]        o_rs1_addr,
    output logic [4:0]        o_rs2_addr,
    input  logic [VLEN-1:0]   i_rs1_data,
    input  logic [VLEN-1:0]   i_rs2_data,
    output logic [VLEN-1:0]   o_alu_a,
    output logic [VLEN-1:0]   o_alu_b,
    output logic [5:0]        o_alu_ctrl,
    output logic [10:0]       o_alu_sew,
    input  logic [VLEN-1:0]   i_alu_result,
    output logic              o_we,
    output logic [4:0]        o_wd_addr,
    output logic [VLEN-1:0]   o_wd_data,
    output logic [VLEN/8-1:0] o_wd_strb,
    output logic              o_done,
`ifdef VEXEC_VX_EN
    input  logic              i_vx,
    input  logic [63:0]       i_scalar,
`endif
    output logic              o_illegal
);
    localparam int NB = VLEN / 8;

    typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

    state_t            state, state_nx;
    logic [5:0]        ctrl;
    logic [10:0]       sew;
    logic [1:0]        lmul;
    logic [7:0]        vl;
    logic [4:0]        vd, vs1, vs2;
    logic [2:0]        k;
    logic [VLEN-1:0]   opa, opb, res;
    logic              done_q, illegal_q;
    logic              legal, last, busy;
    logic [15:0]       nbytes;
    logic [NB-1:0]     strb;
    logic [VLEN-1:0]   b_src;

    assign legal = i_sew == 11'd8 || i_sew == 11'd16 || i_sew == 11'd32 ||
                   i_sew == 11'd64 || i_sew == 11'd128;
    assign last  = k == (3'd1 << lmul) - 3'd1;
    assign busy  = state != IDLE;

`ifdef VEXEC_VX_EN
    logic        vx;
    logic [63:0] scalar;

    // Element i of the replicated scalar takes scalar bit (i mod sew); SEW=128 zero-extends.
    function automatic logic [VLEN-1:0] rep(input logic [63:0] s, input logic [10:0] w);
        for (int i = 0; i < VLEN; i++)
            rep[i] = w == 11'd8  ? s[i % 8]  :
                     w == 11'd16 ? s[i % 16] :
                     w == 11'd32 ? s[i % 32] :
                     w == 11'd64 ? s[i % 64] :
                     (i % 128 < 64) ? s[i % 64] : 1'b0;
    endfunction

    assign b_src = vx ? rep(scalar, sew) : i_rs1_data;
`else
    assign b_src = i_rs1_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            ctrl      <= '0;
            sew       <= '0;
            lmul      <= '0;
            vl        <= '0;
            vd        <= '0;
            vs1       <= '0;
            vs2       <= '0;
            k         <= '0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef VEXEC_VX_EN
            vx        <= 1'b0;
            scalar    <= '0;
`endif
        end else begin
            state     <= state_nx;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                IDLE: if (i_valid) begin
                    ctrl      <= i_ctrl;
                    sew       <= i_sew;
                    lmul      <= i_lmul;
                    vl        <= i_vl;
                    vd        <= i_vd;
                    vs1       <= i_vs1;
                    vs2       <= i_vs2;
                    k         <= '0;
                    illegal_q <= !legal;
                    done_q    <= legal && i_vl == 8'd0;
`ifdef VEXEC_VX_EN
                    vx        <= i_vx;
                    scalar    <= i_scalar;
`endif
                end
                RD: begin
                    opa <= i_rs2_data;
                    opb <= b_src;
                end
                EX: res <= i_alu_result;
                default: if (!last) k <= k + 3'd1;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (i_valid && legal && i_vl != 8'd0) ? RD : IDLE;
            RD:      state_nx = EX;
            EX:      state_nx = WB;
            default: state_nx = last ? IDLE : RD;
        endcase
    end

    // Bytes covered by the active elements; tail bytes past this stay untouched.
    assign nbytes = 16'(vl) * 16'(sew[10:3]);

    always_comb begin
        strb = '0;
        for (int j = 0; j < NB; j++)
            strb[j] = state == WB && (16'(k) * 16'(NB) + 16'(j) < nbytes);
    end

    assign o_ready    = !busy;
    assign o_rs1_addr = state == RD ? vs1 + 5'(k) : '0;
    assign o_rs2_addr = state == RD ? vs2 + 5'(k) : '0;
    assign o_alu_a    = busy ? opa : '0;
    assign o_alu_b    = busy ? opb : '0;
    assign o_alu_ctrl = busy ? ctrl : '0;
    assign o_alu_sew  = busy ? sew : '0;
    assign o_wd_strb  = strb;
    assign o_we       = |strb;
    assign o_wd_addr  = state == WB ? vd + 5'(k) : '0;
    assign o_wd_data  = state == WB ? res : '0;
    assign o_done     = done_q || (state == WB && last);
    assign o_illegal  = illegal_q;
endmodule
